// File: rtl/step_dir_decoder.sv
// rtl/step_dir_decoder.sv - step/direction position decoder with idle timeout and step period capture
// Optional step glitch filter is compiled in when STEP_GLITCH_FILTER_EN is defined.
module step_dir_decoder #(
  parameter logic [15:0] POS_RESET    = 16'd32768,
  parameter int unsigned IDLE_TIMEOUT = 50000,
  parameter int unsigned FILT_LEN     = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        step_in,
  input  logic        dir_in,
  input  logic        load_en,
  input  logic [15:0] load_val,
  input  logic [15:0] goal_pulse,
  output logic [15:0] now_pulse,
  output logic        step_valid,
  output logic        moving,
  output logic        at_goal,
  output logic        pos_err,
  output logic [15:0] step_period
);

  typedef enum logic {ST_IDLE = 1'b0, ST_MOVING = 1'b1} state_t;

`ifdef STEP_GLITCH_FILTER_EN
  localparam int unsigned FILT_THR_I = FILT_LEN;
`else
  localparam int unsigned FILT_THR_I = 1;
`endif
  localparam int unsigned        FILT_W    = $clog2(FILT_LEN + 1);
  localparam logic [FILT_W-1:0]  FILT_THR  = FILT_W'(FILT_THR_I);
  localparam logic [FILT_W-1:0]  FILT_LAST = FILT_W'(FILT_THR_I - 1);
  localparam logic [31:0]        IDLE_LAST = 32'(IDLE_TIMEOUT - 1);

  logic              step_s1_q, step_s1_d, step_s2_q, step_s2_d;
  logic              dir_s1_q, dir_s1_d, dir_s2_q, dir_s2_d;
  logic              primed_q, primed_d, armed_q, armed_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [15:0]       now_q, now_d;
  logic              step_valid_q, step_valid_d;
  logic              pos_err_q, pos_err_d;
  logic              at_goal_q, at_goal_d;
  logic [15:0]       period_cnt_q, period_cnt_d;
  logic [15:0]       step_period_q, step_period_d;
  logic [31:0]       idle_cnt_q, idle_cnt_d;
  state_t            state_q, state_d;
  logic              accept;

  always_comb begin
    step_s1_d     = step_in;
    step_s2_d     = step_s1_q;
    dir_s1_d      = dir_in;
    dir_s2_d      = dir_s1_q;
    primed_d      = 1'b1;
    // A level already high when reset releases must drop before any edge counts.
    armed_d       = armed_q | (primed_q & ~step_s1_q);
    filt_cnt_d    = filt_cnt_q;
    now_d         = now_q;
    pos_err_d     = pos_err_q;
    step_period_d = step_period_q;
    period_cnt_d  = (period_cnt_q == 16'hFFFF) ? period_cnt_q : period_cnt_q + 16'd1;
    idle_cnt_d    = idle_cnt_q;
    state_d       = state_q;
    at_goal_d     = (now_q == goal_pulse) && (state_q == ST_IDLE);

    // Counts consecutive high samples; a threshold of 1 degenerates to a plain rising edge.
    if (!step_s2_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q != FILT_THR) begin
      filt_cnt_d = filt_cnt_q + FILT_W'(1);
    end
    accept       = step_s2_q && (filt_cnt_q == FILT_LAST) && armed_q;
    step_valid_d = accept;

    if (accept) begin
      period_cnt_d  = 16'd1;
      step_period_d = period_cnt_q;
      if (dir_s2_q) begin
        if (now_q == 16'h0000) pos_err_d = 1'b1;
        else                   now_d     = now_q - 16'd1;
      end else begin
        if (now_q == 16'hFFFF) pos_err_d = 1'b1;
        else                   now_d     = now_q + 16'd1;
      end
    end

    if (load_en) begin
      now_d     = load_val;
      pos_err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        if (accept) state_d = ST_MOVING;
      end
      ST_MOVING: begin
        if (accept) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          idle_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 32'd1;
        end
      end
      default: begin
        idle_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      step_s1_q     <= 1'b0;
      step_s2_q     <= 1'b0;
      dir_s1_q      <= 1'b0;
      dir_s2_q      <= 1'b0;
      primed_q      <= 1'b0;
      armed_q       <= 1'b0;
      filt_cnt_q    <= '0;
      now_q         <= POS_RESET;
      step_valid_q  <= 1'b0;
      pos_err_q     <= 1'b0;
      at_goal_q     <= 1'b0;
      period_cnt_q  <= '0;
      step_period_q <= '0;
      idle_cnt_q    <= '0;
      state_q       <= ST_IDLE;
    end else begin
      step_s1_q     <= step_s1_d;
      step_s2_q     <= step_s2_d;
      dir_s1_q      <= dir_s1_d;
      dir_s2_q      <= dir_s2_d;
      primed_q      <= primed_d;
      armed_q       <= armed_d;
      filt_cnt_q    <= filt_cnt_d;
      now_q         <= now_d;
      step_valid_q  <= step_valid_d;
      pos_err_q     <= pos_err_d;
      at_goal_q     <= at_goal_d;
      period_cnt_q  <= period_cnt_d;
      step_period_q <= step_period_d;
      idle_cnt_q    <= idle_cnt_d;
      state_q       <= state_d;
    end
  end

  assign now_pulse   = now_q;
  assign step_valid  = step_valid_q;
  assign moving      = (state_q == ST_MOVING);
  assign at_goal     = at_goal_q;
  assign pos_err     = pos_err_q;
  assign step_period = step_period_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// tb/tb_step_dir_decoder.sv - directed self-checking bench for step_dir_decoder
module tb_step_dir_decoder;

  logic        sys_clk = 1'b0;
  logic        sys_rst, step_in, dir_in, load_en;
  logic [15:0] load_val, goal_pulse;
  logic [15:0] now_pulse, step_period;
  logic        step_valid, moving, at_goal, pos_err;

  int n_checks = 0;
  int n_fail   = 0;
  int sv_total = 0;

`ifdef STEP_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  step_dir_decoder dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .step_in(step_in), .dir_in(dir_in),
    .load_en(load_en), .load_val(load_val), .goal_pulse(goal_pulse),
    .now_pulse(now_pulse), .step_valid(step_valid), .moving(moving),
    .at_goal(at_goal), .pos_err(pos_err), .step_period(step_period)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (step_valid === 1'b1) sv_total <= sv_total + 1;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic step_pulse(input int hi, input int total);
    step_in = 1'b1; cyc(hi);
    step_in = 1'b0; cyc(total - hi);
  endtask

  task automatic test_reset;
    sys_rst = 1'b1; step_in = 1'b0; dir_in = 1'b0; load_en = 1'b0;
    load_val = 16'd0; goal_pulse = 16'd0;
    cyc(3);
    n_checks++; if (now_pulse !== 16'd32768) begin n_fail++; $display("FAIL reset_now: got %0d want 32768", now_pulse); end
    n_checks++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL reset_step_valid: got %b want 0", step_valid); end
    n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %b want 0", moving); end
    n_checks++; if (at_goal !== 1'b0) begin n_fail++; $display("FAIL reset_at_goal: got %b want 0", at_goal); end
    n_checks++; if (pos_err !== 1'b0) begin n_fail++; $display("FAIL reset_pos_err: got %b want 0", pos_err); end
    n_checks++; if (step_period !== 16'd0) begin n_fail++; $display("FAIL reset_step_period: got %0d want 0", step_period); end
    sys_rst = 1'b0;
    cyc(3);
  endtask

  task automatic test_count_up;
    int base;
    dir_in = 1'b0; cyc(3);
    base = sv_total;
    repeat (10) step_pulse(6, 12);
    n_checks++; if (now_pulse !== 16'd32778) begin n_fail++; $display("FAIL up_now: got %0d want 32778", now_pulse); end
    n_checks++; if (sv_total - base !== 10) begin n_fail++; $display("FAIL up_strobes: got %0d want 10", sv_total - base); end
    n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL up_moving: got %b want 1", moving); end
    n_checks++; if (step_period !== 16'd12) begin n_fail++; $display("FAIL up_period: got %0d want 12", step_period); end
  endtask

  task automatic test_saturate;
    load_val = 16'd1; load_en = 1'b1; cyc(1); load_en = 1'b0;
    n_checks++; if (now_pulse !== 16'd1) begin n_fail++; $display("FAIL sat_load: got %0d want 1", now_pulse); end
    dir_in = 1'b1; cyc(3);
    repeat (3) step_pulse(6, 12);
    n_checks++; if (now_pulse !== 16'd0) begin n_fail++; $display("FAIL sat_now: got %0d want 0", now_pulse); end
    n_checks++; if (pos_err !== 1'b1) begin n_fail++; $display("FAIL sat_pos_err: got %b want 1", pos_err); end
    load_val = 16'd500; load_en = 1'b1; cyc(1); load_en = 1'b0;
    n_checks++; if (pos_err !== 1'b0) begin n_fail++; $display("FAIL sat_err_clear: got %b want 0", pos_err); end
    n_checks++; if (now_pulse !== 16'd500) begin n_fail++; $display("FAIL sat_reload: got %0d want 500", now_pulse); end
  endtask

  task automatic test_load_collision;
    int base;
    base = sv_total;
    load_val = 16'd100;
    step_in = 1'b1; cyc(LAT - 1);
    load_en = 1'b1; cyc(1); load_en = 1'b0;
    n_checks++; if (now_pulse !== 16'd100) begin n_fail++; $display("FAIL coll_now: got %0d want 100", now_pulse); end
    n_checks++; if (step_valid !== 1'b1) begin n_fail++; $display("FAIL coll_strobe: got %b want 1", step_valid); end
    cyc(1);
    n_checks++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL coll_strobe_width: got %b want 0", step_valid); end
    cyc(2); step_in = 1'b0; cyc(6);
    n_checks++; if (sv_total - base !== 1) begin n_fail++; $display("FAIL coll_strobes: got %0d want 1", sv_total - base); end
    n_checks++; if (now_pulse !== 16'd100) begin n_fail++; $display("FAIL coll_hold: got %0d want 100", now_pulse); end
  endtask

  task automatic test_period_idle;
    int i;
    dir_in = 1'b0; goal_pulse = 16'd104; cyc(3);
    repeat (4) step_pulse(6, 200);
    n_checks++; if (step_period !== 16'd200) begin n_fail++; $display("FAIL per_period: got %0d want 200", step_period); end
    n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL per_moving: got %b want 1", moving); end
    n_checks++; if (at_goal !== 1'b0) begin n_fail++; $display("FAIL per_at_goal_moving: got %b want 0", at_goal); end
    i = 0;
    while (moving === 1'b1 && i < 60000) begin cyc(1); i++; end
    n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL idle_timeout: moving %b after %0d cycles want 0", moving, i); end
    n_checks++; if (i < 49790 || i > 49820) begin n_fail++; $display("FAIL idle_timing: got %0d cycles want 49790..49820", i); end
    n_checks++; if (at_goal !== 1'b0) begin n_fail++; $display("FAIL goal_lag: got %b want 0", at_goal); end
    cyc(1);
    n_checks++; if (at_goal !== 1'b1) begin n_fail++; $display("FAIL goal_set: got %b want 1", at_goal); end
    n_checks++; if (now_pulse !== 16'd104) begin n_fail++; $display("FAIL goal_now: got %0d want 104", now_pulse); end
  endtask

  task automatic test_filter;
    int base;
    logic [15:0] start;
    dir_in = 1'b0; cyc(3);
    base = sv_total; start = now_pulse;
`ifdef STEP_GLITCH_FILTER_EN
    step_pulse(2, 12);
    n_checks++; if (sv_total - base !== 0) begin n_fail++; $display("FAIL glitch_strobes: got %0d want 0", sv_total - base); end
    n_checks++; if (now_pulse !== start) begin n_fail++; $display("FAIL glitch_now: got %0d want %0d", now_pulse, start); end
    step_pulse(6, 12);
`else
    step_pulse(1, 12);
`endif
    n_checks++; if (sv_total - base !== 1) begin n_fail++; $display("FAIL short_strobes: got %0d want 1", sv_total - base); end
    n_checks++; if (now_pulse !== start + 16'd1) begin n_fail++; $display("FAIL short_now: got %0d want %0d", now_pulse, start + 16'd1); end
  endtask

  task automatic test_reset_held;
    int base;
    step_in = 1'b0; cyc(2);
    base = sv_total;
    step_in = 1'b1; cyc(2);
    sys_rst = 1'b1; cyc(1);
    n_checks++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL abort_strobe: got %b want 0", step_valid); end
    n_checks++; if (now_pulse !== 16'd32768) begin n_fail++; $display("FAIL abort_now: got %0d want 32768", now_pulse); end
    cyc(2); sys_rst = 1'b0; cyc(10);
    n_checks++; if (sv_total - base !== 0) begin n_fail++; $display("FAIL held_strobes: got %0d want 0", sv_total - base); end
    n_checks++; if (now_pulse !== 16'd32768) begin n_fail++; $display("FAIL held_now: got %0d want 32768", now_pulse); end
    n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL held_moving: got %b want 0", moving); end
    step_in = 1'b0; cyc(6);
    step_pulse(6, 12);
    n_checks++; if (now_pulse !== 16'd32769) begin n_fail++; $display("FAIL rearm_now: got %0d want 32769", now_pulse); end
    n_checks++; if (sv_total - base !== 1) begin n_fail++; $display("FAIL rearm_strobes: got %0d want 1", sv_total - base); end
  endtask

  initial begin
    sys_rst = 1'b1; step_in = 1'b0; dir_in = 1'b0; load_en = 1'b0;
    load_val = 16'd0; goal_pulse = 16'd0;
    cyc(1);
    test_reset;
    test_count_up;
    test_saturate;
    test_load_collision;
    test_period_idle;
    test_filter;
    test_reset_held;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
